// File: rtl/powlib_ipmemtest.sv
// powlib_ipmemtest
//   Memory self-test master for a powlib IP-packet memory. On a start pulse it
//   writes a seeded pattern to words B_BASE..B_BASE+B_SIZE, then reads them all
//   back. At most MAXOUT reads are kept in flight. Every response is checked
//   against the pattern, and mismatches are counted. Responses may return in
//   any order, because each one carries its word index in its return address.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous reset, active low
//   start     in   one-cycle pulse, begins a test when idle
//   wrdata    out  request packet {op, be, data}
//   wraddr    out  request word address
//   wrvld     out  request valid
//   wrrdy     in   request ready
//   rddata    in   response packet {op, be, data}
//   rdaddr    in   response (return) address
//   rdvld     in   response valid
//   rdrdy     out  response ready (READ and DRAIN only)
//   busy      out  test in progress
//   done      out  test finished, sticky until next start
//   pass      out  finished with zero mismatches
//   errcnt    out  mismatch count, saturating
//   firsterr  out  word address of first mismatch

`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef POWLIB_OPW
`define POWLIB_OPW 4
`endif
`ifndef POWLIB_OP_WRITE
`define POWLIB_OP_WRITE 4'h0
`endif
`ifndef POWLIB_OP_READ
`define POWLIB_OP_READ 4'h1
`endif

module powlib_ipmemtest #(
    parameter int          B_BPD  = 2,
    parameter logic [15:0] B_BASE = 16'h5555,
    parameter logic [15:0] B_SIZE = 16'h0010,
    parameter logic [15:0] B_RET  = 16'h0000,
    parameter logic [15:0] SEED   = 16'hA5C3,
    parameter int          MAXOUT = 4,
    localparam int B_AW  = `POWLIB_BW*B_BPD,
    localparam int B_DW  = `POWLIB_BW*B_BPD,
    localparam int B_BEW = B_BPD,
    localparam int B_OPW = `POWLIB_OPW,
    localparam int B_WW  = B_DW+B_BEW+B_OPW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [B_WW-1:0] wrdata,
    output logic [B_AW-1:0] wraddr,
    output logic            wrvld,
    input  logic            wrrdy,
    input  logic [B_WW-1:0] rddata,
    input  logic [B_AW-1:0] rdaddr,
    input  logic            rdvld,
    output logic            rdrdy,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     errcnt,
    output logic [B_AW-1:0] firsterr
);

    localparam logic [B_AW-1:0]  L_BASE   = B_AW'(B_BASE);
    localparam logic [B_AW-1:0]  L_SIZE   = B_AW'(B_SIZE);
    localparam logic [B_AW-1:0]  L_RET    = B_AW'(B_RET);
    localparam logic [B_DW-1:0]  L_SEED   = B_DW'(SEED);
    localparam logic [B_BEW-1:0] L_BE_ALL = '1;
    localparam logic [B_OPW-1:0] L_OP_WR  = B_OPW'(`POWLIB_OP_WRITE);
    localparam logic [B_OPW-1:0] L_OP_RD  = B_OPW'(`POWLIB_OP_READ);
    localparam logic [3:0]       L_MAXOUT = 4'(MAXOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [B_AW-1:0] r_idx;
    logic [3:0]      r_out;
    logic [15:0]     r_errcnt;
    logic [B_AW-1:0] r_firsterr;
    logic            r_done;
    logic            r_pass;

    logic [B_AW-1:0]  w_reqaddr;
    logic             w_wrvld;
    logic             w_wrxfer;
    logic             w_rdreq;
    logic             w_rdrdy;
    logic             w_rdxfer;
    logic             w_last;
    logic [B_AW-1:0]  w_respidx;
    logic [B_OPW-1:0] w_respop;
    logic [B_DW-1:0]  w_respdata;
    logic [B_DW-1:0]  w_expdata;
    logic             w_mismatch;
    logic [B_OPW-1:0] w_reqop;
    logic [B_DW-1:0]  w_reqfield;
    logic             w_unused_be;

    assign w_reqaddr = L_BASE + r_idx;
    assign w_last    = (r_idx == L_SIZE);

    // Reads are throttled purely by the outstanding count. The count only
    // rises on an accepted request, so a presented request is never withdrawn.
    assign w_wrvld  = (r_state == S_WRITE) ||
                      ((r_state == S_READ) && (r_out != L_MAXOUT));
    assign w_wrxfer = w_wrvld && wrrdy;
    assign w_rdreq  = w_wrxfer && (r_state == S_READ);
    assign w_rdrdy  = (r_state == S_READ) || (r_state == S_DRAIN);
    assign w_rdxfer = rdvld && w_rdrdy;

    // The return address encodes the word index, so out-of-order responses
    // can be checked without tracking request order.
    assign w_respidx   = rdaddr - L_RET;
    assign w_respop    = rddata[B_WW-1 -: B_OPW];
    assign w_respdata  = rddata[B_DW-1:0];
    assign w_expdata   = B_DW'(L_BASE + w_respidx) ^ L_SEED;
    assign w_mismatch  = w_rdxfer &&
                         ((w_respop != L_OP_WR) || (w_respdata != w_expdata));
    assign w_unused_be = ^rddata[B_DW +: B_BEW];

    always_comb begin
        w_reqop    = L_OP_WR;
        w_reqfield = B_DW'(w_reqaddr) ^ L_SEED;
        if (r_state == S_READ) begin
            w_reqop    = L_OP_RD;
            w_reqfield = B_DW'(L_RET + r_idx);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_WRITE;
            S_WRITE: if (w_wrxfer && w_last) w_next = S_READ;
            S_READ:  if (w_wrxfer && w_last) w_next = S_DRAIN;
            S_DRAIN: if (r_out == 4'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx      <= '0;
            r_out      <= '0;
            r_errcnt   <= '0;
            r_firsterr <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_idx      <= '0;
            r_out      <= '0;
            r_errcnt   <= '0;
            r_firsterr <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            if (w_wrxfer) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end

            if (w_rdreq && !w_rdxfer) begin
                r_out <= r_out + 4'd1;
            end else if (!w_rdreq && w_rdxfer) begin
                r_out <= r_out - 4'd1;
            end

            // errcnt saturates and never returns to zero mid-test, so a zero
            // count marks the first mismatch.
            if (w_mismatch) begin
                if (r_errcnt != 16'hFFFF) begin
                    r_errcnt <= r_errcnt + 16'd1;
                end
                if (r_errcnt == 16'd0) begin
                    r_firsterr <= L_BASE + w_respidx;
                end
            end

            if ((r_state == S_DRAIN) && (r_out == 4'd0)) begin
                r_done <= 1'b1;
                r_pass <= (r_errcnt == 16'd0);
            end
        end
    end

    assign wrvld    = w_wrvld;
    assign wraddr   = w_reqaddr;
    assign wrdata   = {w_reqop, L_BE_ALL, w_reqfield};
    assign rdrdy    = w_rdrdy;
    assign busy     = (r_state == S_WRITE) || (r_state == S_READ) ||
                      (r_state == S_DRAIN);
    assign done     = r_done;
    assign pass     = r_pass;
    assign errcnt   = r_errcnt;
    assign firsterr = r_firsterr;

endmodule

// File: tb/tb_powlib_ipmemtest.sv
// tb_powlib_ipmemtest
//   Directed bench for powlib_ipmemtest with default parameters. A small
//   ipram-like responder stores writes and answers reads with {WRITE, be, data}
//   at the read's return address. The responder can stall, corrupt one word,
//   or reverse response order. Expected values are hand-derived from the
//   pattern (B_BASE+i) ^ SEED.

module tb_powlib_ipmemtest;

    localparam logic [3:0] OP_WR = 4'h0;
    localparam logic [3:0] OP_RD = 4'h1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [21:0] wrdata;
    logic [15:0] wraddr;
    logic        wrvld;
    logic        wrrdy;
    logic [21:0] rddata;
    logic [15:0] rdaddr;
    logic        rdvld;
    logic        rdrdy;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] errcnt;
    logic [15:0] firsterr;

    powlib_ipmemtest #(
        .B_BPD  (2),
        .B_BASE (16'h5555),
        .B_SIZE (16'h0010),
        .B_RET  (16'h0000),
        .SEED   (16'hA5C3),
        .MAXOUT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .wrdata   (wrdata),
        .wraddr   (wraddr),
        .wrvld    (wrvld),
        .wrrdy    (wrrdy),
        .rddata   (rddata),
        .rdaddr   (rdaddr),
        .rdvld    (rdvld),
        .rdrdy    (rdrdy),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .errcnt   (errcnt),
        .firsterr (firsterr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct packed {
        logic [15:0] ret;
        logic [15:0] addr;
    } rd_t;

    logic [15:0] mem [0:65535];
    rd_t         respq[$];
    rd_t         batch[$];
    int          n_wr, n_rd, n_resp;
    int          wr_bad, rd_bad, hold_bad;
    bit          stall, rand_rdy, reverse, corrupt;
    bit          prev_stall;
    logic [15:0] prev_addr;
    logic [21:0] prev_data;

    // Runs at a negedge: checks hold, drives inputs for the next rising edge,
    // and updates the model with the transfers that edge will perform.
    task automatic body();
        logic [15:0] a;
        logic [3:0]  op;
        rd_t         e;
        if (prev_stall) begin
            if (!wrvld || wraddr !== prev_addr || wrdata !== prev_data) hold_bad++;
        end
        wrrdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

        if (batch.size() == 0 && respq.size() > 0) begin
            if (!reverse) batch.push_back(respq.pop_front());
            else if (respq.size() >= 4 || n_rd == 17)
                while (respq.size() > 0) batch.push_back(respq.pop_back());
        end
        if (!stall && batch.size() > 0) begin
            a      = batch[0].addr;
            rdvld  = 1'b1;
            rdaddr = batch[0].ret;
            rddata = {OP_WR, 2'b11, mem[a] ^ ((corrupt && a == 16'h555A) ? 16'h0001 : 16'h0000)};
        end else begin
            rdvld  = 1'b0;
            rdaddr = '0;
            rddata = '0;
        end

        if (wrvld && wrrdy) begin
            op = wrdata[21:18];
            if (op == OP_WR) begin
                if (wraddr !== 16'(16'h5555 + n_wr) ||
                    wrdata[15:0] !== (16'(16'h5555 + n_wr) ^ 16'hA5C3) ||
                    wrdata[17:16] !== 2'b11) wr_bad++;
                mem[wraddr] = wrdata[15:0];
                n_wr++;
            end else begin
                if (op !== OP_RD || wraddr !== 16'(16'h5555 + n_rd) ||
                    wrdata[15:0] !== 16'(n_rd) || wrdata[17:16] !== 2'b11) rd_bad++;
                e.ret  = wrdata[15:0];
                e.addr = wraddr;
                respq.push_back(e);
                n_rd++;
            end
        end
        if (rdvld && rdrdy) begin
            void'(batch.pop_front());
            n_resp++;
        end
        prev_stall = wrvld && !wrrdy;
        prev_addr  = wraddr;
        prev_data  = wrdata;
    endtask

    task automatic do_start();
        n_wr = 0; n_rd = 0; n_resp = 0;
        wr_bad = 0; rd_bad = 0; hold_bad = 0;
        prev_stall = 1'b0;
        respq.delete();
        batch.delete();
        @(negedge clk);
        start = 1'b1;
        wrrdy = 1'b0;
        rdvld = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("first_vld", 32'(wrvld), 32'd1);
        check("first_addr", 32'(wraddr), 32'h5555);
        check("first_data", 32'(wrdata), 32'h3F096);
    endtask

    task automatic run_until_done(input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            body();
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_reached_done"}, 32'(ok), 32'd1);
    endtask

    task automatic end_checks(input string tag, input logic exp_pass,
                              input logic [15:0] exp_err, input logic [15:0] exp_first);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        check({tag, "_errcnt"}, 32'(errcnt), 32'(exp_err));
        check({tag, "_firsterr"}, 32'(firsterr), 32'(exp_first));
        check({tag, "_nwr"}, 32'(n_wr), 32'd17);
        check({tag, "_nrd"}, 32'(n_rd), 32'd17);
        check({tag, "_nresp"}, 32'(n_resp), 32'd17);
        check({tag, "_wrseq"}, 32'(wr_bad), 32'd0);
        check({tag, "_rdseq"}, 32'(rd_bad), 32'd0);
        check({tag, "_hold"}, 32'(hold_bad), 32'd0);
        rdvld = 1'b0;
        @(negedge clk);
        check({tag, "_done_held"}, 32'(done), 32'd1);
        check({tag, "_pass_held"}, 32'(pass), 32'(exp_pass));
        check({tag, "_idle_vld"}, 32'(wrvld), 32'd0);
        check({tag, "_idle_rdrdy"}, 32'(rdrdy), 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; wrrdy = 1'b0; rdvld = 1'b0;
        rddata = '0; rdaddr = '0;
        stall = 0; rand_rdy = 0; reverse = 0; corrupt = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_errcnt", 32'(errcnt), 32'd0);
        check("rst_firsterr", 32'(firsterr), 32'd0);
        check("rst_wrvld", 32'(wrvld), 32'd0);
        check("rst_rdrdy", 32'(rdrdy), 32'd0);
        rst = 1'b1;

        // Ideal responder
        do_start();
        run_until_done("ideal");
        end_checks("ideal", 1'b1, 16'd0, 16'd0);

        // One corrupted word
        corrupt = 1;
        do_start();
        run_until_done("corrupt");
        end_checks("corrupt", 1'b0, 16'd1, 16'h555A);
        corrupt = 0;

        // Responses stalled: reads must stop at 4 outstanding
        stall = 1;
        do_start();
        for (int c = 0; c < 60; c++) begin
            body();
            @(negedge clk);
        end
        check("stall_nrd", 32'(n_rd), 32'd4);
        check("stall_wrvld", 32'(wrvld), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        stall = 0;
        run_until_done("stall");
        end_checks("stall", 1'b1, 16'd0, 16'd0);

        // Random request backpressure
        rand_rdy = 1;
        do_start();
        run_until_done("randrdy");
        end_checks("randrdy", 1'b1, 16'd0, 16'd0);
        rand_rdy = 0;

        // Reversed response order per window of 4
        reverse = 1;
        do_start();
        run_until_done("reverse");
        end_checks("reverse", 1'b1, 16'd0, 16'd0);
        reverse = 0;

        // Reset mid-READ with 3 outstanding
        stall = 1;
        do_start();
        for (int c = 0; c < 100 && n_rd < 3; c++) begin
            body();
            @(negedge clk);
        end
        check("midrst_nrd", 32'(n_rd), 32'd3);
        rst = 1'b0; wrrdy = 1'b0; rdvld = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wrvld", 32'(wrvld), 32'd0);
        check("midrst_rdrdy", 32'(rdrdy), 32'd0);
        check("midrst_errcnt", 32'(errcnt), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        stall = 0;
        do_start();
        run_until_done("afterrst");
        end_checks("afterrst", 1'b1, 16'd0, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
